// File: rtl/pipeline_run_controller.sv
// rtl/pipeline_run_controller.sv - run/step/pause/clear sequencer with HALT detect and drain for the 5-stage pipeline
// Optional RUN watchdog enabled by defining MIPS_RUN_WATCHDOG_EN.
module pipeline_run_controller #(
  parameter int         PIPE_DEPTH  = 5,
  parameter int         CNT_W       = 32,
  parameter logic [5:0] HALT_OPCODE = 6'b111111,
  parameter int         WDOG_CYCLES = 1000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd,
  input  logic [5:0]       id_opcode,
  input  logic             id_valid,
  output logic             pc_enable,
  output logic             pipe_enable,
  output logic             pipe_clear,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_count
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_STEP  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [1:0] CMD_RUN   = 2'b00;
  localparam logic [1:0] CMD_STEP  = 2'b01;
  localparam logic [1:0] CMD_PAUSE = 2'b10;
  localparam logic [1:0] CMD_CLEAR = 2'b11;

  // Drain covers EX, MEM and WB; the counter is loaded with the last index.
  localparam int         DRAIN_LEN  = PIPE_DEPTH - 2;
  localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_LEN - 1);

  state_t     state, state_next;
  logic [7:0] drain_cnt;
  logic       cmd_accept;
  logic       halt_seen;
  logic       clear_req;
  logic       wdog_hit;
  logic       wdog_expire;
  logic       count_sat;

  assign halt_seen = id_valid && (id_opcode == HALT_OPCODE);
  assign count_sat = (cycle_count == {CNT_W{1'b1}});

`ifdef MIPS_RUN_WATCHDOG_EN
  localparam logic [CNT_W-1:0] WDOG_LIMIT = CNT_W'(WDOG_CYCLES);
  // True on the enabled cycle whose increment lands exactly on the budget.
  assign wdog_hit = !count_sat && ((cycle_count + 1'b1) == WDOG_LIMIT);
`else
  assign wdog_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    clear_req   = 1'b0;
    wdog_expire = 1'b0;
    pc_enable   = 1'b0;
    pipe_enable = 1'b0;
    cmd_ready   = 1'b0;
    cmd_accept  = 1'b0;
    case (state)
      S_IDLE: begin
        cmd_ready  = 1'b1;
        cmd_accept = cmd_valid;
        if (cmd_accept) begin
          case (cmd)
            CMD_RUN:   state_next = S_RUN;
            CMD_STEP:  state_next = S_STEP;
            CMD_CLEAR: clear_req  = 1'b1;
            default:   state_next = S_IDLE;
          endcase
        end
      end
      S_RUN: begin
        cmd_ready   = 1'b1;
        cmd_accept  = cmd_valid;
        pc_enable   = 1'b1;
        pipe_enable = 1'b1;
        // Halt outranks both watchdog expiry and a same-cycle PAUSE.
        if (halt_seen) begin
          state_next = S_DRAIN;
        end else if (wdog_hit) begin
          state_next  = S_DONE;
          wdog_expire = 1'b1;
        end else if (cmd_accept && (cmd == CMD_PAUSE)) begin
          state_next = S_IDLE;
        end
      end
      S_STEP: begin
        pc_enable   = 1'b1;
        pipe_enable = 1'b1;
        state_next  = halt_seen ? S_DRAIN : S_IDLE;
      end
      S_DRAIN: begin
        pipe_enable = 1'b1;
        if (drain_cnt == 8'd0) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        cmd_ready  = 1'b1;
        cmd_accept = cmd_valid;
        if (cmd_accept && (cmd == CMD_CLEAR)) begin
          state_next = S_IDLE;
          clear_req  = 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_clear  <= 1'b0;
      done        <= 1'b0;
      timeout     <= 1'b0;
      cycle_count <= '0;
      drain_cnt   <= 8'd0;
    end else begin
      // Back-to-back CLEARs still give isolated one-cycle pulses.
      pipe_clear <= clear_req && !pipe_clear;
      done       <= (state_next == S_DONE);
`ifdef MIPS_RUN_WATCHDOG_EN
      if (wdog_expire) begin
        timeout <= 1'b1;
      end else if (state_next != S_DONE) begin
        timeout <= 1'b0;
      end
`else
      timeout <= 1'b0;
`endif
      if (clear_req) begin
        cycle_count <= '0;
      end else if (pipe_enable && !count_sat) begin
        cycle_count <= cycle_count + 1'b1;
      end
      if ((state_next == S_DRAIN) && (state != S_DRAIN)) begin
        drain_cnt <= DRAIN_LAST;
      end else if ((state == S_DRAIN) && (drain_cnt != 8'd0)) begin
        drain_cnt <= drain_cnt - 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_run_controller.sv
// tb/tb_pipeline_run_controller.sv - directed self-checking bench for pipeline_run_controller
module tb_pipeline_run_controller;

  localparam int WDOG = 40;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd;
  logic [5:0]  id_opcode;
  logic        id_valid;
  logic        pc_enable;
  logic        pipe_enable;
  logic        pipe_clear;
  logic        done;
  logic        timeout;
  logic [31:0] cycle_count;

  int checks_run;
  int checks_failed;

  pipeline_run_controller #(
    .PIPE_DEPTH (5),
    .CNT_W      (32),
    .HALT_OPCODE(6'b111111),
    .WDOG_CYCLES(WDOG)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd        (cmd),
    .id_opcode  (id_opcode),
    .id_valid   (id_valid),
    .pc_enable  (pc_enable),
    .pipe_enable(pipe_enable),
    .pipe_clear (pipe_clear),
    .done       (done),
    .timeout    (timeout),
    .cycle_count(cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_run++;
    if (got !== exp) begin
      checks_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [1:0] c);
    for (int i = 0; i < 50 && !cmd_ready; i++) cyc(1);
    check("cmd_ready_wait", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd       = c;
    cyc(1);
    cmd_valid = 1'b0;
  endtask

  task automatic halt_cycle();
    id_valid  = 1'b1;
    id_opcode = 6'b111111;
    cyc(1);
    id_valid  = 1'b0;
    id_opcode = 6'b000000;
  endtask

  initial begin
    checks_run    = 0;
    checks_failed = 0;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd       = 2'b00;
    id_opcode = 6'b000000;
    id_valid  = 1'b0;
    cyc(2);
    check("rst_pc_enable", pc_enable, 0);
    check("rst_pipe_enable", pipe_enable, 0);
    check("rst_pipe_clear", pipe_clear, 0);
    check("rst_done", done, 0);
    check("rst_count", cycle_count, 0);
    check("rst_cmd_ready", cmd_ready, 1);
    rst_n = 1'b1;
    cyc(1);

    // 1: RUN, HALT on 10th enabled cycle
    send(2'b00);
    check("t1_first_enabled", pc_enable, 1);
    check("t1_first_count", cycle_count, 0);
    id_opcode = 6'b111110;
    id_valid  = 1'b1;
    cyc(9);
    check("t1_nonhalt_ignored", pc_enable, 1);
    halt_cycle();
    check("t1_drain_pc", pc_enable, 0);
    check("t1_drain_pipe", pipe_enable, 1);
    check("t1_drain_ready", cmd_ready, 0);
    check("t1_drain_count", cycle_count, 10);
    cyc(2);
    check("t1_drain3_pipe", pipe_enable, 1);
    check("t1_drain3_done", done, 0);
    cyc(1);
    check("t1_done", done, 1);
    check("t1_done_pipe", pipe_enable, 0);
    check("t1_count", cycle_count, 13);
    send(2'b11);
    check("t1_clear_pulse", pipe_clear, 1);
    check("t1_clear_count", cycle_count, 0);
    cyc(1);
    check("t1_clear_width", pipe_clear, 0);

    // 2: three STEPs
    for (int s = 0; s < 3; s++) begin
      send(2'b01);
      check("t2_step_pc", pc_enable, 1);
      check("t2_step_ready", cmd_ready, 0);
      cyc(1);
      check("t2_after_step_pipe", pipe_enable, 0);
    end
    check("t2_count", cycle_count, 3);
    check("t2_idle_ready", cmd_ready, 1);
    send(2'b11);

    // 3: RUN, PAUSE after 5, RUN, HALT after 4 more
    send(2'b00);
    cyc(4);
    send(2'b10);
    check("t3_paused_pipe", pipe_enable, 0);
    check("t3_paused_count", cycle_count, 5);
    cyc(3);
    check("t3_frozen_count", cycle_count, 5);
    send(2'b00);
    cyc(3);
    halt_cycle();
    cyc(3);
    check("t3_done", done, 1);
    check("t3_count", cycle_count, 12);
    send(2'b11);

    // 4: HALT and PAUSE together, then RUN ignored in DONE, CLEAR
    send(2'b00);
    cmd_valid = 1'b1;
    cmd       = 2'b10;
    halt_cycle();
    cmd_valid = 1'b0;
    check("t4_drain_pc", pc_enable, 0);
    check("t4_drain_pipe", pipe_enable, 1);
    cyc(3);
    check("t4_done", done, 1);
    check("t4_count", cycle_count, 4);
    send(2'b00);
    check("t4_run_ignored_done", done, 1);
    check("t4_run_ignored_pipe", pipe_enable, 0);
    send(2'b11);
    check("t4_clear_pulse", pipe_clear, 1);
    check("t4_clear_done", done, 0);
    check("t4_clear_count", cycle_count, 0);
    cyc(1);
    check("t4_clear_width", pipe_clear, 0);

    // 5: async reset in 2nd drain cycle
    send(2'b00);
    halt_cycle();
    cyc(1);
    check("t5_in_drain", pipe_enable, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_async_pipe", pipe_enable, 0);
    check("t5_async_pc", pc_enable, 0);
    check("t5_async_count", cycle_count, 0);
    check("t5_async_done", done, 0);
    #2 rst_n = 1'b1;
    cyc(1);
    check("t5_idle_ready", cmd_ready, 1);
    check("t5_idle_pipe", pipe_enable, 0);

    // 6: watchdog / no-watchdog run without HALT
    send(2'b00);
`ifdef MIPS_RUN_WATCHDOG_EN
    cyc(WDOG - 1);
    check("t6_pre_expiry_timeout", timeout, 0);
    cyc(1);
    check("t6_done", done, 1);
    check("t6_timeout", timeout, 1);
    check("t6_count", cycle_count, WDOG);
    send(2'b11);
    check("t6_clear_timeout", timeout, 0);
`else
    cyc(WDOG + 4);
    check("t6_still_running", pc_enable, 1);
    check("t6_no_timeout", timeout, 0);
    check("t6_no_done", done, 0);
    send(2'b10);
    check("t6_count", cycle_count, WDOG + 5);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks_run, checks_failed);
    $finish;
  end

endmodule
